// File: rtl/load_store_unit.sv
// load_store_unit: executes one load/store request on a single-port data
// memory bus (req/ack) and returns load data as a register writeback beat.
// Misaligned or illegal-funct3 requests and bus timeouts end in a 1-cycle
// error pulse with no writeback.
module load_store_unit #(
  parameter int XLEN     = 32,
  parameter int REGSEL_W = 5,
  parameter int TIMEOUT  = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iReqValid,
  input  logic                iRead,
  input  logic                iWrite,
  input  logic [XLEN-1:0]     iAddr,
  input  logic [XLEN-1:0]     iData,
  input  logic [2:0]          iOpType,
  input  logic [REGSEL_W-1:0] iRdAddr,
  output logic                oBusy,
  output logic                oMemReq,
  output logic                oMemWe,
  output logic [XLEN-1:0]     oMemAddr,
  output logic [XLEN-1:0]     oMemWData,
  output logic [3:0]          oMemBe,
  input  logic                iMemAck,
  input  logic [XLEN-1:0]     iMemRData,
  output logic                oRegDv,
  output logic [REGSEL_W-1:0] oRegAddr,
  output logic [XLEN-1:0]     oRegData,
  output logic                oStoreDone,
  output logic                oErr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Counter only needs to reach TIMEOUT-1: the abort happens on the edge
  // that closes the last unacknowledged REQ cycle.
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  // Byte enables: sub-word accesses shift a 1- or 2-byte mask into the lane.
  function automatic logic [3:0] f_be(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   f_be = 4'b0001 << a;
      2'b01:   f_be = 4'b0011 << a;
      default: f_be = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across all lanes so the memory just applies BE.
  function automatic logic [XLEN-1:0] f_wdata(input logic [2:0] op, input logic [XLEN-1:0] d);
    case (op[1:0])
      2'b00:   f_wdata = {4{d[7:0]}};
      2'b01:   f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  // Legal funct3 values with their natural alignment requirement.
  function automatic logic f_legal(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: f_legal = 1'b1;
      3'b001, 3'b101: f_legal = ~a[0];
      3'b010:         f_legal = (a == 2'b00);
      default:        f_legal = 1'b0;
    endcase
  endfunction

  // Select the addressed lane of the read word and sign/zero extend it.
  function automatic logic [XLEN-1:0] f_load(input logic [2:0] op, input logic [1:0] lane,
                                             input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'b000:  f_load = {{24{b[7]}}, b};
      3'b100:  f_load = {24'd0, b};
      3'b001:  f_load = {{16{h[15]}}, h};
      3'b101:  f_load = {16'd0, h};
      default: f_load = rdata;
    endcase
  endfunction

  logic [1:0]          state_q, state_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          lane_q, lane_d;
  logic [REGSEL_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [XLEN-1:0]     regdata_q, regdata_d;
  logic                storedone_q, storedone_d;

  // Next-state logic: request capture, bus handshake, timeout and writeback.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    op_d        = op_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    tmo_d       = tmo_q;
    regdata_d   = regdata_q;
    storedone_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iReqValid && (iRead || iWrite)) begin
          // A request flagged as both read and write is executed as a load.
          we_d    = iWrite & ~iRead;
          addr_d  = {iAddr[XLEN-1:2], 2'b00};
          wdata_d = f_wdata(iOpType, iData);
          be_d    = f_be(iOpType, iAddr[1:0]);
          op_d    = iOpType;
          lane_d  = iAddr[1:0];
          rd_d    = iRdAddr;
          tmo_d   = '0;
          state_d = f_legal(iOpType, iAddr[1:0]) ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        if (iMemAck) begin
          if (we_q) begin
            storedone_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            regdata_d = f_load(op_q, lane_q, iMemRData);
            state_d   = ST_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so all outputs read 0.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      rd_q        <= '0;
      tmo_q       <= '0;
      regdata_q   <= '0;
      storedone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      tmo_q       <= tmo_d;
      regdata_q   <= regdata_d;
      storedone_q <= storedone_d;
    end
  end

  assign oBusy      = (state_q != ST_IDLE);
  assign oMemReq    = (state_q == ST_REQ);
  assign oErr       = (state_q == ST_ERR);
  assign oMemWe     = we_q;
  assign oMemAddr   = addr_q;
  assign oMemWData  = wdata_q;
  assign oMemBe     = be_q;
  // Loads to x0 still run the bus cycle but never raise a writeback.
  assign oRegDv     = (state_q == ST_WB) && (rd_q != '0);
  assign oRegAddr   = rd_q;
  assign oRegData   = regdata_q;
  assign oStoreDone = storedone_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed corner cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReqValid, iRead, iWrite;
  logic [31:0] iAddr, iData;
  logic [2:0]  iOpType;
  logic [4:0]  iRdAddr;
  logic        oBusy, oMemReq, oMemWe;
  logic [31:0] oMemAddr, oMemWData;
  logic [3:0]  oMemBe;
  logic        iMemAck;
  logic [31:0] iMemRData;
  logic        oRegDv;
  logic [4:0]  oRegAddr;
  logic [31:0] oRegData;
  logic        oStoreDone, oErr;

  int n_chk  = 0;
  int n_fail = 0;

  load_store_unit #(.XLEN(32), .REGSEL_W(5), .TIMEOUT(TMO)) dut (
    .iClk(iClk), .iRst(iRst), .iReqValid(iReqValid), .iRead(iRead), .iWrite(iWrite),
    .iAddr(iAddr), .iData(iData), .iOpType(iOpType), .iRdAddr(iRdAddr),
    .oBusy(oBusy), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .oMemBe(oMemBe), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oRegDv(oRegDv), .oRegAddr(oRegAddr), .oRegData(oRegData),
    .oStoreDone(oStoreDone), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Access size in bytes from funct3; 0 marks an illegal encoding.
  function automatic int ref_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] op, input logic [31:0] addr);
    int sz;
    sz = ref_size(op);
    return (sz != 0) && ((addr % sz) == 0);
  endfunction

  function automatic logic [31:0] ref_be(input logic [2:0] op, input logic [31:0] addr);
    int sz;
    sz = ref_size(op);
    if (sz == 4) return 32'hF;
    return ((1 << sz) - 1) << (addr % 4);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] d);
    int sz;
    sz = ref_size(op);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned v;
    int unsigned sh;
    sh = 8 * (addr % 4);
    case (op)
      3'd0: begin v = (rdata >> sh) & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd4: v = (rdata >> sh) & 32'hFF;
      3'd1: begin v = (rdata >> sh) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd5: v = (rdata >> sh) & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  // One complete transaction, starting and ending at posedge+1 with the unit idle.
  // waits = cycles of REQ before the ack; waits >= TMO means no ack at all.
  task automatic txn(input bit rd_, input bit wr_, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [4:0] rdreg, input int waits,
                     input logic [31:0] rdata, input string nm);
    bit legal, is_load, tmo;
    bit e_req, e_err, e_sd, e_dv, e_busy, e_wb;
    int n, last;
    legal   = ref_legal(op, addr);
    is_load = rd_;
    n       = waits + 1;
    tmo     = legal && (waits >= TMO);
    last    = !legal ? 2 : (tmo ? TMO + 2 : n + 2);

    iReqValid = 1'b1; iRead = rd_; iWrite = wr_;
    iAddr = addr; iData = data; iOpType = op; iRdAddr = rdreg;
    @(posedge iClk); #1;
    iReqValid = 1'b0;

    for (int c = 1; c <= last; c++) begin
      e_req  = legal && (c <= (tmo ? TMO : n));
      e_err  = (!legal && c == 1) || (tmo && c == TMO + 1);
      e_wb   = legal && !tmo && is_load && (c == n + 1);
      e_sd   = legal && !tmo && !is_load && (c == n + 1);
      e_dv   = e_wb && (rdreg != 5'd0);
      e_busy = e_req || e_err || e_wb;

      if (e_req) begin
        iMemAck   = !tmo && (c == n);
        iMemRData = (c == n) ? rdata : $urandom;
      end else begin
        iMemAck   = 1'($urandom % 2);
        iMemRData = $urandom;
      end
      // While busy, throw unrelated requests at the unit; they must be ignored.
      iReqValid = e_busy ? 1'($urandom % 2) : 1'b0;
      iRead = 1'($urandom % 2); iWrite = 1'($urandom % 2);
      iAddr = $urandom; iData = $urandom; iOpType = 3'($urandom % 8);
      iRdAddr = 5'($urandom % 32);

      @(negedge iClk);
      chk($sformatf("%s c%0d busy/req/err/sd/dv", nm, c),
          {27'd0, oBusy, oMemReq, oErr, oStoreDone, oRegDv},
          {27'd0, e_busy, e_req, e_err, e_sd, e_dv});
      if (e_req) begin
        chk($sformatf("%s c%0d addr", nm, c), oMemAddr, addr & 32'hFFFF_FFFC);
        chk($sformatf("%s c%0d be", nm, c), {28'd0, oMemBe}, ref_be(op, addr));
        chk($sformatf("%s c%0d we", nm, c), {31'd0, oMemWe}, {31'd0, !is_load});
        if (!is_load) chk($sformatf("%s c%0d wdata", nm, c), oMemWData, ref_wdata(op, data));
      end
      if (e_dv) begin
        chk($sformatf("%s regaddr", nm), {27'd0, oRegAddr}, {27'd0, rdreg});
        chk($sformatf("%s regdata", nm), oRegData, ref_load(op, addr, rdata));
      end
      @(posedge iClk); #1;
    end
    iMemAck   = 1'b0;
    iReqValid = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {oBusy, oMemReq, oMemWe, oRegDv, oStoreDone, oErr, 26'd0} |
           oMemAddr | oMemWData | {28'd0, oMemBe} | {27'd0, oRegAddr} | oRegData;
  endfunction

  initial begin
    bit r, w;
    logic [2:0] op;
    int waits;
    logic [2:0] legal_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    iRst = 1'b0; iReqValid = 1'b0; iRead = 1'b0; iWrite = 1'b0;
    iAddr = '0; iData = '0; iOpType = '0; iRdAddr = '0;
    iMemAck = 1'b0; iMemRData = '0;
    repeat (2) @(posedge iClk);
    #1;
    chk("reset outputs", all_outs(), 32'd0);
    iRst = 1'b1;
    @(negedge iClk);
    chk("post-reset outputs", all_outs(), 32'd0);
    @(posedge iClk); #1;

    txn(1, 0, 3'd2, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF, "lw");
    txn(1, 0, 3'd0, 32'h103, 32'h0, 5'd7, 0, 32'h80112233, "lb");
    txn(1, 0, 3'd4, 32'h103, 32'h0, 5'd7, 1, 32'h80112233, "lbu");
    txn(0, 1, 3'd1, 32'h102, 32'h0000ABCD, 5'd0, 3, 32'h0, "sh");
    txn(1, 0, 3'd2, 32'h101, 32'h0, 5'd4, 0, 32'h0, "lw_mis");
    txn(1, 0, 3'd2, 32'h104, 32'h0, 5'd5, TMO, 32'h12345678, "lw_tmo");
    txn(1, 0, 3'd5, 32'h106, 32'h0, 5'd9, 0, 32'hBEEF7777, "lhu_after_tmo");
    txn(0, 1, 3'd2, 32'h208, 32'hCAFEF00D, 5'd1, TMO - 1, 32'h0, "sw_last_cycle_ack");
    txn(1, 0, 3'd2, 32'h20C, 32'h0, 5'd0, 0, 32'h55AA55AA, "lw_x0");
    txn(1, 1, 3'd1, 32'h212, 32'h0, 5'd2, 2, 32'h8001FFFF, "rw_as_load");
    txn(0, 1, 3'd3, 32'h300, 32'h0, 5'd2, 0, 32'h0, "illegal_op");
    txn(0, 1, 3'd0, 32'h301, 32'h000000A5, 5'd2, 0, 32'h0, "sb");

    // Reset in the middle of a bus request, then a late ack must do nothing.
    iReqValid = 1'b1; iRead = 1'b1; iWrite = 1'b0;
    iAddr = 32'h400; iOpType = 3'd2; iRdAddr = 5'd6;
    @(posedge iClk); #1;
    iReqValid = 1'b0;
    chk("rst: req raised", {31'd0, oMemReq}, 32'd1);
    #3 iRst = 1'b0;
    #1 chk("rst: outputs cleared", all_outs(), 32'd0);
    @(posedge iClk); #1;
    iRst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      iMemAck = 1'b1; iMemRData = $urandom;
      @(negedge iClk);
      chk($sformatf("rst: late ack c%0d", c), all_outs() & 32'hFC00_0000, 32'd0);
      @(posedge iClk); #1;
    end
    iMemAck = 1'b0;
    txn(1, 0, 3'd0, 32'h402, 32'h0, 5'd8, 0, 32'h00FE0000, "lb_after_rst");

    for (int t = 0; t < 60; t++) begin
      r = 1'($urandom % 2);
      w = r ? 1'($urandom % 2) : 1'b1;
      op = ($urandom % 4 == 0) ? 3'($urandom % 8) : legal_ops[$urandom % 5];
      waits = ($urandom % 8 == 0) ? TMO + int'($urandom % 2) : int'($urandom % 5);
      txn(r, w, op, $urandom, $urandom, 5'($urandom % 32), waits, $urandom,
          $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
